significand_divider: RTL and testbench
======================================

# significand_divider

Sequential significand datapath for the FPU single-precision divide path, the counterpart of the multiplier significand path. It takes the two 23-bit fractions and the zero-exponent flags, pre-normalises subnormal operands, and computes a 26-bit quotient by restoring division, one bit per cycle. It then normalises and rounds the quotient into a 24-bit significand, and reports to the exponent unit the shift counts and the flags it needs to form Ez.

## Interface
Parameters: none (binary32 significands fixed).
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- Mx, My  in  23  dividend / divisor fractions
- zero_Ex, zero_Ey  in  1  exponent-is-zero; hidden bit = ~zero_E
- R_mode  in  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
- Sz  in  1  result sign (directed rounding)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, results valid
- Mz  out  24  rounded significand, hidden bit at [23]
- SHLx, SHLy  out  5  left shifts applied to dividend / divisor during alignment
- norm  out  1  quotient < 1 (exponent −1)
- Overflow_after_round  out  1  rounding carried out of bit 23
- inexact_flag  out  1  guard | sticky was nonzero
- div_by_zero  out  1  divisor significand zero

## Operation
- States: IDLE, ALIGN, DIV, ROUND.
- IDLE, start=1: load A={~zero_Ex,Mx}, B={~zero_Ey,My}; latch R_mode and Sz; clear SHL counters.
  - If B==0: set div_by_zero and go to ROUND (special).
  - Else if A==0: go to ROUND (special, zero result).
  - Else go to ALIGN.
- ALIGN, each cycle:
  - If A[23]==0, shift A left 1 and SHLx++. If B[23]==0, shift B left 1 and SHLy++. Both shift in parallel.
  - If both MSBs are set: no shift; go to DIV. Remainder R(25b)=A, counter=25.
- DIV, 26 cycles:
  - If R≥B: q bit=1, R=R−B; else q bit=0.
  - Then R=R<<1. q shifts in LSB-first into q[25:0].
  - Counter reaches 0 → ROUND.
- ROUND, non-special case:
  - If q[25]=1: m=q[25:2], G=q[1], S=q[0]|(R≠0), norm=0.
  - Else: m=q[24:1], G=q[0], S=(R≠0), norm=1.
  - Increment conditions:
    - RNE: G&(S|m[0]).
    - RTZ: never.
    - +inf: ~Sz&(G|S).
    - −inf: Sz&(G|S).
  - If m+inc carries out, Mz=24'h800000 and Overflow_after_round=1.
  - inexact_flag=G|S.
- ROUND, special case: Mz=0, norm=0, inexact_flag=0.
- ROUND always goes to IDLE.
- start while busy is ignored. Inputs need not be held after the start edge.

## Timing
- Reset (asynchronous): state IDLE. All outputs 0, including busy, done, Mz, SHLx, SHLy, and every flag.
- RST asserted mid-operation: abort immediately to the reset state; no done pulse is produced.
- All outputs are registered.
  - Mz, SHLx, SHLy, norm and the flags update on the ROUND→IDLE edge, together with done=1.
  - They hold until the next start is accepted; they are not cleared at start.
- Latency from the start edge to done high:
  - Normal operands: 28+k cycles, k=max(SHLx,SHLy). This is 28 for two normalised operands and 51 at most.
  - Special cases (zero divisor or zero dividend): 2 cycles.
- busy rises the cycle after the start edge and falls with done.
- start in the same cycle as done=1 is accepted, since the state is IDLE.

## Test plan
- Mx=0x400000, My=0, zero flags 0, RNE (1.5/1.0) → Mz=0xC00000, norm=0, inexact=0, SHLx=SHLy=0, done at cycle 28.
- Mx=0, My=0x400000 (1.0/1.5):
  - RNE → Mz=0xAAAAAB, norm=1, inexact=1.
  - RTZ → Mz=0xAAAAAA.
  - −inf with Sz=1 → 0xAAAAAB.
- zero_Ex=1, Mx=0x000001, My=0 → SHLx=23, SHLy=0, Mz=0x800000, inexact=0, done at cycle 51.
- zero_Ey=1, My=0 → div_by_zero=1, Mz=0, done 2 cycles after start. zero_Ex=1, Mx=0 → Mz=0, div_by_zero=0.
- Mx=0x7FFFFF, My=0 → Mz=0xFFFFFF exact. Also random normal/subnormal pairs checked against a reference model with Mz·2^(SHLy−SHLx−norm) ≈ A/B, across all R_mode values.
- Assert RST at DIV cycle 10 → busy=0 and outputs 0 immediately. A new start then completes normally with no stale done.

Source files
------------

// File: rtl/significand_divider.sv
// significand_divider
// Sequential significand datapath for the single-precision divide path.
// Pre-normalises subnormal operands, produces a 26-bit quotient by
// restoring division (one bit per cycle), then normalises and rounds it
// to a 24-bit significand with the hidden bit at [23].
//
// Ports:
//   CLK, RST              clock (rising edge), async active-high reset
//   start                 request, sampled only while idle
//   Mx, My                dividend / divisor fractions (23 bits)
//   zero_Ex, zero_Ey      exponent-is-zero flags (hidden bit = ~flag)
//   R_mode                00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   Sz                    result sign, used by directed rounding
//   busy                  high whenever not idle
//   done                  one-cycle pulse, results valid
//   Mz                    rounded significand
//   SHLx, SHLy            alignment left shifts of dividend / divisor
//   norm                  quotient < 1 (exponent unit subtracts one)
//   Overflow_after_round  rounding carried out of bit 23
//   inexact_flag          guard | sticky nonzero
//   div_by_zero           divisor significand was zero
module significand_divider (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [22:0] Mx,
  input  logic [22:0] My,
  input  logic        zero_Ex,
  input  logic        zero_Ey,
  input  logic [1:0]  R_mode,
  input  logic        Sz,
  output logic        busy,
  output logic        done,
  output logic [23:0] Mz,
  output logic [4:0]  SHLx,
  output logic [4:0]  SHLy,
  output logic        norm,
  output logic        Overflow_after_round,
  output logic        inexact_flag,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, ALIGN, DIV, ROUND} state_t;

  state_t      state_q, state_d;
  logic [23:0] a_q, b_q;
  logic [24:0] r_q;
  logic [25:0] q_q;
  logic [4:0]  cnt_q, shlx_q, shly_q;
  logic [1:0]  rmode_q;
  logic        sz_q, special_q, dbzPend_q;

  logic        busy_q, done_q, norm_q, ovf_q, inexact_q, dbz_q;
  logic [23:0] mz_q;
  logic [4:0]  shlxOut_q, shlyOut_q;

  logic [23:0] aIn, bIn;
  logic [24:0] divisorExt, diff, rem;
  logic        ge;
  logic [23:0] m;
  logic        g, s, inc;
  logic [24:0] sum;

  assign aIn        = {~zero_Ex, Mx};
  assign bIn        = {~zero_Ey, My};
  assign divisorExt = {1'b0, b_q};
  assign ge         = (r_q >= divisorExt);
  assign diff       = r_q - divisorExt;
  assign rem        = ge ? diff : r_q;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Special operands (zero divisor or dividend) take one
  // pass-through cycle in ALIGN so that their done lands two cycles after
  // start; their A/B are never shifted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ALIGN;
      ALIGN: begin
        if (special_q)               state_d = ROUND;
        else if (a_q[23] && b_q[23]) state_d = DIV;
      end
      DIV:   if (cnt_q == 5'd0) state_d = ROUND;
      ROUND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding of the finished quotient. When q[25] is clear the quotient
  // is below one and everything is taken one bit lower.
  always_comb begin
    m   = q_q[25:2];
    g   = q_q[1];
    s   = q_q[0] | (r_q != 25'd0);
    inc = 1'b0;
    if (!q_q[25]) begin
      m = q_q[24:1];
      g = q_q[0];
      s = (r_q != 25'd0);
    end
    case (rmode_q)
      2'b00: inc = g & (s | m[0]);
      2'b01: inc = 1'b0;
      2'b10: inc = ~sz_q & (g | s);
      2'b11: inc = sz_q & (g | s);
      default: inc = 1'b0;
    endcase
    sum = {1'b0, m} + {24'd0, inc};
  end

  // Datapath: operand capture, alignment shifts and the restoring
  // divide loop. The remainder never exceeds 2B, so 25 bits suffice.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      shlx_q    <= '0;
      shly_q    <= '0;
      rmode_q   <= '0;
      sz_q      <= 1'b0;
      special_q <= 1'b0;
      dbzPend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q       <= aIn;
          b_q       <= bIn;
          rmode_q   <= R_mode;
          sz_q      <= Sz;
          shlx_q    <= '0;
          shly_q    <= '0;
          dbzPend_q <= (bIn == 24'd0);
          special_q <= (bIn == 24'd0) || (aIn == 24'd0);
        end
        ALIGN: if (!special_q) begin
          if (a_q[23] && b_q[23]) begin
            r_q   <= {1'b0, a_q};
            q_q   <= '0;
            cnt_q <= 5'd25;
          end else begin
            if (!a_q[23]) begin
              a_q    <= a_q << 1;
              shlx_q <= shlx_q + 5'd1;
            end
            if (!b_q[23]) begin
              b_q    <= b_q << 1;
              shly_q <= shly_q + 5'd1;
            end
          end
        end
        DIV: begin
          q_q   <= {q_q[24:0], ge};
          r_q   <= rem << 1;
          cnt_q <= cnt_q - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Output registers: results are captured on the ROUND->IDLE edge and
  // then held until a later operation completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mz_q      <= '0;
      shlxOut_q <= '0;
      shlyOut_q <= '0;
      norm_q    <= 1'b0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == ROUND);
      if (state_q == ROUND) begin
        shlxOut_q <= shlx_q;
        shlyOut_q <= shly_q;
        dbz_q     <= dbzPend_q;
        if (special_q) begin
          mz_q      <= '0;
          norm_q    <= 1'b0;
          ovf_q     <= 1'b0;
          inexact_q <= 1'b0;
        end else begin
          mz_q      <= sum[24] ? 24'h800000 : sum[23:0];
          norm_q    <= ~q_q[25];
          ovf_q     <= sum[24];
          inexact_q <= g | s;
        end
      end
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign Mz                   = mz_q;
  assign SHLx                 = shlxOut_q;
  assign SHLy                 = shlyOut_q;
  assign norm                 = norm_q;
  assign Overflow_after_round = ovf_q;
  assign inexact_flag         = inexact_q;
  assign div_by_zero          = dbz_q;

endmodule

// File: tb/tb_significand_divider.sv
// Testbench for significand_divider: a directed table of hand-computed
// divisions, hand-written sequences for reset and ignored start, and a
// batch of random operands checked against a behavioural division model.
module tb_significand_divider;

   logic        CLK, RST, start;
   logic [22:0] Mx, My;
   logic        zero_Ex, zero_Ey;
   logic [1:0]  R_mode;
   logic        Sz;
   logic        busy, done;
   logic [23:0] Mz;
   logic [4:0]  SHLx, SHLy;
   logic        norm, Overflow_after_round, inexact_flag, div_by_zero;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [22:0] mx, my;
      logic        zex, zey;
      logic [1:0]  rm;
      logic        sz;
      logic [23:0] eMz;
      logic        eNorm, eInex, eDbz, eOvf;
      logic [4:0]  eShlx, eShly;
      int          eLat;
   } vec_t;

   significand_divider dut (
      .CLK(CLK), .RST(RST), .start(start),
      .Mx(Mx), .My(My), .zero_Ex(zero_Ex), .zero_Ey(zero_Ey),
      .R_mode(R_mode), .Sz(Sz),
      .busy(busy), .done(done), .Mz(Mz), .SHLx(SHLx), .SHLy(SHLy),
      .norm(norm), .Overflow_after_round(Overflow_after_round),
      .inexact_flag(inexact_flag), .div_by_zero(div_by_zero)
   );

   // Free-running clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // One comparison, counted and reported on failure
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [22:0] mx, my, input logic zex, zey,
                               input logic [1:0] rm, input logic sz,
                               input logic [23:0] eMz, input logic eNorm, eInex, eDbz,
                               input logic [4:0] eShlx, eShly, input int eLat);
      vec_t v;
      v.mx = mx; v.my = my; v.zex = zex; v.zey = zey; v.rm = rm; v.sz = sz;
      v.eMz = eMz; v.eNorm = eNorm; v.eInex = eInex; v.eDbz = eDbz; v.eOvf = 1'b0;
      v.eShlx = eShlx; v.eShly = eShly; v.eLat = eLat;
      return v;
   endfunction

   // Behavioural reference: normalise by counting, divide with wide integer
   // arithmetic, then round the 26-bit quotient.
   function automatic vec_t refModel(input logic [22:0] mx, my, input logic zex, zey,
                                     input logic [1:0] rm, input logic sz);
      vec_t v;
      logic [23:0] a, b, m;
      logic [63:0] num, q, r;
      logic        g, s, inc;
      logic [24:0] sum;
      v = mk(mx, my, zex, zey, rm, sz, 24'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2);
      a = {~zex, mx};
      b = {~zey, my};
      if (b == 24'd0) begin
         v.eDbz = 1'b1;
      end else if (a != 24'd0) begin
         while (!a[23]) begin a = a << 1; v.eShlx = v.eShlx + 5'd1; end
         while (!b[23]) begin b = b << 1; v.eShly = v.eShly + 5'd1; end
         num = {40'd0, a} << 25;
         q = num / {40'd0, b};
         r = num % {40'd0, b};
         if (q[25]) begin
            m = q[25:2]; g = q[1]; s = q[0] | (r != 64'd0); v.eNorm = 1'b0;
         end else begin
            m = q[24:1]; g = q[0]; s = (r != 64'd0); v.eNorm = 1'b1;
         end
         case (rm)
            2'b00:   inc = g & (s | m[0]);
            2'b10:   inc = ~sz & (g | s);
            2'b11:   inc = sz & (g | s);
            default: inc = 1'b0;
         endcase
         sum = {1'b0, m} + {24'd0, inc};
         v.eMz  = sum[24] ? 24'h800000 : sum[23:0];
         v.eOvf = sum[24];
         v.eInex = g | s;
         v.eLat = 28 + ((v.eShlx > v.eShly) ? int'(v.eShlx) : int'(v.eShly));
      end
      return v;
   endfunction

   // Issue one operation and wait (bounded) for done. A nonzero noiseCycle
   // raises start for one cycle mid-operation, which must be ignored.
   task automatic applyStimulus(input vec_t v, input int noiseCycle, output int lat);
      Mx = v.mx; My = v.my; zero_Ex = v.zex; zero_Ey = v.zey;
      R_mode = v.rm; Sz = v.sz; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      Mx = 23'($urandom); My = 23'($urandom);
      zero_Ex = 1'($urandom); zero_Ey = 1'($urandom);
      R_mode = 2'($urandom); Sz = 1'($urandom);
      chk("busy after start", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge CLK); #1;
         lat++;
         start = (lat == noiseCycle);
      end
      start = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input vec_t v, input int lat);
      chk({tag, " latency"}, lat, v.eLat);
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " busy low"}, {31'd0, busy}, 32'd0);
      chk({tag, " Mz"}, {8'd0, Mz}, {8'd0, v.eMz});
      chk({tag, " norm"}, {31'd0, norm}, {31'd0, v.eNorm});
      chk({tag, " inexact"}, {31'd0, inexact_flag}, {31'd0, v.eInex});
      chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.eDbz});
      chk({tag, " overflow"}, {31'd0, Overflow_after_round}, {31'd0, v.eOvf});
      chk({tag, " SHLx"}, {27'd0, SHLx}, {27'd0, v.eShlx});
      chk({tag, " SHLy"}, {27'd0, SHLy}, {27'd0, v.eShly});
   endtask

   task automatic checkCleared(input string tag);
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " done"}, {31'd0, done}, 32'd0);
      chk({tag, " Mz"}, {8'd0, Mz}, 32'd0);
      chk({tag, " SHLx"}, {27'd0, SHLx}, 32'd0);
      chk({tag, " SHLy"}, {27'd0, SHLy}, 32'd0);
      chk({tag, " flags"}, {28'd0, norm, Overflow_after_round, inexact_flag, div_by_zero}, 32'd0);
   endtask

   initial begin
      vec_t tbl[14];
      vec_t v;
      int   lat;

      // Directed vectors: rm 0=RNE 1=RTZ 2=+inf 3=-inf
      //             mx         my         zex   zey   rm     sz    eMz          nrm   inx   dbz   shx    shy    lat
      tbl[0]  = mk(23'h400000, 23'h000000, 1'b0, 1'b0, 2'd0, 1'b0, 24'hC00000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  28);
      tbl[1]  = mk(23'h000000, 23'h400000, 1'b0, 1'b0, 2'd0, 1'b0, 24'hAAAAAB, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[2]  = mk(23'h000000, 23'h400000, 1'b0, 1'b0, 2'd1, 1'b0, 24'hAAAAAA, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[3]  = mk(23'h000000, 23'h400000, 1'b0, 1'b0, 2'd3, 1'b1, 24'hAAAAAB, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[4]  = mk(23'h000000, 23'h400000, 1'b0, 1'b0, 2'd2, 1'b1, 24'hAAAAAA, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[5]  = mk(23'h000000, 23'h400000, 1'b0, 1'b0, 2'd2, 1'b0, 24'hAAAAAB, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[6]  = mk(23'h000001, 23'h000000, 1'b1, 1'b0, 2'd0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 5'd23, 5'd0,  51);
      tbl[7]  = mk(23'h123456, 23'h000000, 1'b0, 1'b1, 2'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  2);
      tbl[8]  = mk(23'h000000, 23'h200000, 1'b1, 1'b0, 2'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  2);
      tbl[9]  = mk(23'h7FFFFF, 23'h000000, 1'b0, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  28);
      tbl[10] = mk(23'h400000, 23'h200000, 1'b0, 1'b0, 2'd0, 1'b0, 24'h99999A, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[11] = mk(23'h400000, 23'h200000, 1'b0, 1'b0, 2'd1, 1'b0, 24'h999999, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  28);
      tbl[12] = mk(23'h000000, 23'h000001, 1'b0, 1'b1, 2'd0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd23, 51);
      tbl[13] = mk(23'h400000, 23'h200000, 1'b1, 1'b1, 2'd0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 5'd1,  5'd2,  30);

      RST = 1'b1; start = 1'b0; Mx = '0; My = '0;
      zero_Ex = 1'b0; zero_Ey = 1'b0; R_mode = 2'd0; Sz = 1'b0;
      #1;
      checkCleared("reset");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Directed table, issued back to back (each start overlaps the
      // previous done cycle)
      foreach (tbl[i]) begin
         applyStimulus(tbl[i], 0, lat);
         checkOutput($sformatf("vec%0d", i), tbl[i], lat);
      end

      // Start pulsed while busy is ignored
      applyStimulus(tbl[0], 5, lat);
      checkOutput("ignored start", tbl[0], lat);

      // Reset in the middle of the divide loop
      Mx = 23'h400000; My = 23'h0; zero_Ex = 1'b0; zero_Ey = 1'b0;
      R_mode = 2'd0; Sz = 1'b0; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (11) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      checkCleared("mid-op reset");
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1;
      applyStimulus(tbl[1], 0, lat);
      checkOutput("after reset", tbl[1], lat);

      // Random normal/subnormal operands against the reference model
      for (int i = 0; i < 16; i++) begin
         v = refModel(23'($urandom), 23'($urandom),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      2'($urandom_range(0, 3)), 1'($urandom));
         applyStimulus(v, 0, lat);
         checkOutput($sformatf("rand%0d", i), v, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
